// File: rtl/jtcontra_gfx_romrq.sv
// SDRAM-side responder for the two graphics ROM read ports (gfx1, gfx2).
// Each port keeps a one-word cache of its last read, so a repeated address
// returns ok in the same cycle. Misses share a single SDRAM read channel.
// The channel is arbitrated round-robin, with one transaction outstanding.
module jtcontra_gfx_romrq #(
  parameter logic [21:0] GFX1_OFFSET = 22'h00_0000,
  parameter logic [21:0] GFX2_OFFSET = 22'h04_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [17:0] gfx1_addr,
  input  logic        gfx1_cs,
  output logic [15:0] gfx1_data,
  output logic        gfx1_ok,
  input  logic [17:0] gfx2_addr,
  input  logic        gfx2_cs,
  output logic [15:0] gfx2_data,
  output logic        gfx2_ok,
  output logic [21:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        sdram_dst,
  input  logic [15:0] sdram_din
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DST} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [21:0] sdram_addr_q, sdram_addr_d;
  logic        port_q, port_d;          // 0 = gfx1, 1 = gfx2
  logic [17:0] cap_addr_q, cap_addr_d;  // client address captured at request time
  logic        last_q, last_d;          // port served most recently
  logic        valid1_q, valid1_d, valid2_q, valid2_d;
  logic [17:0] caddr1_q, caddr1_d, caddr2_q, caddr2_d;
  logic [15:0] cdata1_q, cdata1_d, cdata2_q, cdata2_d;

  logic hit1, hit2, miss1, miss2, sel, fill;

  assign hit1  = valid1_q && (gfx1_addr == caddr1_q);
  assign hit2  = valid2_q && (gfx2_addr == caddr2_q);
  assign miss1 = gfx1_cs && !hit1;
  assign miss2 = gfx2_cs && !hit2;

  assign gfx1_ok    = gfx1_cs && hit1 && !downloading;
  assign gfx2_ok    = gfx2_cs && hit2 && !downloading;
  assign gfx1_data  = cdata1_q;
  assign gfx2_data  = cdata2_q;
  assign sdram_req  = req_q;
  assign sdram_addr = sdram_addr_q;

  // Next-state: arbitration in IDLE, SDRAM handshake, cache fill and flush
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    sdram_addr_d = sdram_addr_q;
    port_d       = port_q;
    cap_addr_d   = cap_addr_q;
    last_d       = last_q;
    valid1_d     = valid1_q;
    valid2_d     = valid2_q;
    caddr1_d     = caddr1_q;
    caddr2_d     = caddr2_q;
    cdata1_d     = cdata1_q;
    cdata2_d     = cdata2_q;
    sel          = 1'b0;
    fill         = 1'b0;

    if (downloading) begin
      valid1_d = 1'b0;
      valid2_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!downloading && (miss1 || miss2)) begin
          // On a tie the port that was not served last wins
          sel          = (miss1 && miss2) ? ~last_q : miss2;
          port_d       = sel;
          cap_addr_d   = sel ? gfx2_addr : gfx1_addr;
          sdram_addr_d = sel ? (GFX2_OFFSET + {4'd0, gfx2_addr})
                             : (GFX1_OFFSET + {4'd0, gfx1_addr});
          req_d        = 1'b1;
          state_d      = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) begin
          req_d = 1'b0;
          if (sdram_dst) begin
            fill    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_DST;
          end
        end
      end
      WAIT_DST: begin
        if (sdram_dst) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The fill uses the captured address, so a client that moved on does not
    // get stale data flagged as its current word. Fills during download are
    // written but left invalid.
    if (fill) begin
      last_d = port_q;
      if (port_q) begin
        caddr2_d = cap_addr_q;
        cdata2_d = sdram_din;
        valid2_d = !downloading;
      end else begin
        caddr1_d = cap_addr_q;
        cdata1_d = sdram_din;
        valid1_d = !downloading;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      sdram_addr_q <= 22'd0;
      port_q       <= 1'b0;
      cap_addr_q   <= 18'd0;
      last_q       <= 1'b1;
      valid1_q     <= 1'b0;
      valid2_q     <= 1'b0;
      caddr1_q     <= 18'd0;
      caddr2_q     <= 18'd0;
      cdata1_q     <= 16'd0;
      cdata2_q     <= 16'd0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      sdram_addr_q <= sdram_addr_d;
      port_q       <= port_d;
      cap_addr_q   <= cap_addr_d;
      last_q       <= last_d;
      valid1_q     <= valid1_d;
      valid2_q     <= valid2_d;
      caddr1_q     <= caddr1_d;
      caddr2_q     <= caddr2_d;
      cdata1_q     <= cdata1_d;
      cdata2_q     <= cdata2_d;
    end
  end

endmodule

// File: tb/tb_jtcontra_gfx_romrq.sv
// Directed bench for jtcontra_gfx_romrq: cache hits, SDRAM handshake,
// round-robin arbitration, download flush and asynchronous reset.
module tb_jtcontra_gfx_romrq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic [17:0] gfx1_addr = '0, gfx2_addr = '0;
  logic        gfx1_cs = 1'b0, gfx2_cs = 1'b0;
  logic [15:0] gfx1_data, gfx2_data;
  logic        gfx1_ok, gfx2_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack = 1'b0, sdram_dst = 1'b0;
  logic [15:0] sdram_din = '0;

  int checks = 0;
  int errors = 0;

  logic        got;
  logic [21:0] got_addr;

  jtcontra_gfx_romrq #(
    .GFX1_OFFSET(22'h00_0000),
    .GFX2_OFFSET(22'h3F_FFF0)
  ) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .gfx1_addr(gfx1_addr), .gfx1_cs(gfx1_cs), .gfx1_data(gfx1_data), .gfx1_ok(gfx1_ok),
    .gfx2_addr(gfx2_addr), .gfx2_cs(gfx2_cs), .gfx2_data(gfx2_data), .gfx2_ok(gfx2_ok),
    .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .sdram_dst(sdram_dst), .sdram_din(sdram_din)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Wait (bounded) for a request, then ack and deliver din; returns in the
  // cycle after the fill edge
  task automatic serve(input logic [15:0] din);
    got = 1'b0;
    got_addr = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (sdram_req) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      got_addr  = sdram_addr;
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
      sdram_dst = 1'b1;
      sdram_din = din;
      tick();
      sdram_dst = 1'b0;
      sdram_din = '0;
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", sdram_req); end
    checks++; if (sdram_addr !== 22'd0) begin errors++; $display("FAIL reset_addr got %h want 0", sdram_addr); end
    checks++; if ({gfx1_ok, gfx2_ok} !== 2'b00) begin errors++; $display("FAIL reset_ok got %b want 00", {gfx1_ok, gfx2_ok}); end
    checks++; if ({gfx1_data, gfx2_data} !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", {gfx1_data, gfx2_data}); end
  endtask

  task automatic test_single_miss();
    gfx1_addr = 18'h00123;
    gfx1_cs   = 1'b1;
    #1;
    checks++; if (gfx1_ok !== 1'b0) begin errors++; $display("FAIL miss_ok_early got %0b want 0", gfx1_ok); end
    tick();
    checks++; if (sdram_req !== 1'b1) begin errors++; $display("FAIL miss_req got %0b want 1", sdram_req); end
    checks++; if (sdram_addr !== 22'h000123) begin errors++; $display("FAIL miss_addr got %h want 000123", sdram_addr); end
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    checks++; if (sdram_req !== 1'b0) begin errors++; $display("FAIL miss_req_drop got %0b want 0", sdram_req); end
    sdram_dst = 1'b1;
    sdram_din = 16'hBEEF;
    #1;
    checks++; if (gfx1_ok !== 1'b0) begin errors++; $display("FAIL miss_ok_at_dst got %0b want 0", gfx1_ok); end
    tick();
    sdram_dst = 1'b0;
    sdram_din = '0;
    #1;
    checks++; if (gfx1_ok !== 1'b1 || gfx1_data !== 16'hBEEF) begin errors++; $display("FAIL miss_fill got ok=%0b data=%h want ok=1 data=beef", gfx1_ok, gfx1_data); end
    tick();
    checks++; if (gfx1_ok !== 1'b1 || sdram_req !== 1'b0) begin errors++; $display("FAIL miss_hold got ok=%0b req=%0b want ok=1 req=0", gfx1_ok, sdram_req); end
    gfx1_cs = 1'b0;
    #1;
    checks++; if (gfx1_ok !== 1'b0) begin errors++; $display("FAIL miss_cs_low got %0b want 0", gfx1_ok); end
  endtask

  task automatic test_wrap();
    gfx2_addr = 18'h00020;
    gfx2_cs   = 1'b1;
    serve(16'h1234);
    checks++; if (!got || got_addr !== 22'h000010) begin errors++; $display("FAIL wrap_addr got %h (req=%0b) want 000010", got_addr, got); end
    checks++; if (gfx2_ok !== 1'b1 || gfx2_data !== 16'h1234) begin errors++; $display("FAIL wrap_fill got ok=%0b data=%h want ok=1 data=1234", gfx2_ok, gfx2_data); end
    gfx2_cs = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [21:0] exp;
    do_reset();
    gfx1_addr = 18'h10;
    gfx2_addr = 18'h20;
    gfx1_cs   = 1'b1;
    gfx2_cs   = 1'b1;
    serve(16'hA001);
    checks++; if (!got || got_addr !== 22'h000010 || gfx1_ok !== 1'b1 || gfx2_ok !== 1'b0) begin errors++; $display("FAIL rr_first got addr=%h ok1=%0b ok2=%0b want addr=000010 ok1=1 ok2=0", got_addr, gfx1_ok, gfx2_ok); end
    serve(16'hA002);
    checks++; if (!got || gfx2_ok !== 1'b1 || gfx2_data !== 16'hA002) begin errors++; $display("FAIL rr_second got ok2=%0b data=%h want ok2=1 data=a002", gfx2_ok, gfx2_data); end
    for (int i = 0; i < 4; i++) begin
      gfx1_addr = 18'h100 + 18'(i);
      gfx2_addr = 18'h300 + 18'(i);
      exp = (i % 2 == 0) ? 22'h000100 + 22'(i) : 22'h0002F0 + 22'(i);
      serve(16'hC000 + 16'(i));
      checks++; if (!got || got_addr !== exp) begin errors++; $display("FAIL rr_alt%0d got %h want %h", i, got_addr, exp); end
    end
    gfx2_cs = 1'b0;
  endtask

  task automatic test_addr_change();
    gfx1_addr = 18'h100;
    gfx1_cs   = 1'b1;
    tick();
    checks++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h000100) begin errors++; $display("FAIL chg_req1 got req=%0b addr=%h want 1 000100", sdram_req, sdram_addr); end
    sdram_ack = 1'b1;
    gfx1_addr = 18'h200;
    tick();
    sdram_ack = 1'b0;
    sdram_dst = 1'b1;
    sdram_din = 16'h1111;
    tick();
    sdram_dst = 1'b0;
    #1;
    checks++; if (gfx1_ok !== 1'b0) begin errors++; $display("FAIL chg_no_ok got %0b want 0", gfx1_ok); end
    tick();
    checks++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h000200) begin errors++; $display("FAIL chg_req2 got req=%0b addr=%h want 1 000200", sdram_req, sdram_addr); end
    gfx1_addr = 18'h100;
    #1;
    checks++; if (gfx1_ok !== 1'b1 || gfx1_data !== 16'h1111) begin errors++; $display("FAIL chg_back_hit got ok=%0b data=%h want 1 1111", gfx1_ok, gfx1_data); end
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    sdram_dst = 1'b1;
    sdram_din = 16'h2222;
    tick();
    sdram_dst = 1'b0;
    sdram_din = '0;
    #1;
    checks++; if (gfx1_ok !== 1'b0) begin errors++; $display("FAIL chg_overwrite got %0b want 0", gfx1_ok); end
    serve(16'h1111);
    checks++; if (!got || got_addr !== 22'h000100 || gfx1_ok !== 1'b1) begin errors++; $display("FAIL chg_rerequest got addr=%h ok=%0b want 000100 1", got_addr, gfx1_ok); end
  endtask

  task automatic test_download();
    gfx2_addr = 18'h50;
    gfx2_cs   = 1'b1;
    serve(16'h5555);
    checks++; if (gfx1_ok !== 1'b1 || gfx2_ok !== 1'b1) begin errors++; $display("FAIL dl_pre got ok1=%0b ok2=%0b want 1 1", gfx1_ok, gfx2_ok); end
    gfx2_addr = 18'h60;
    tick();
    checks++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h000050) begin errors++; $display("FAIL dl_inflight got req=%0b addr=%h want 1 000050", sdram_req, sdram_addr); end
    downloading = 1'b1;
    sdram_ack   = 1'b1;
    #1;
    checks++; if (gfx1_ok !== 1'b0 || gfx2_ok !== 1'b0) begin errors++; $display("FAIL dl_ok0 got %0b%0b want 00", gfx1_ok, gfx2_ok); end
    tick();
    sdram_ack = 1'b0;
    sdram_dst = 1'b1;
    sdram_din = 16'h6666;
    for (int c = 1; c < 5; c++) begin
      #1;
      checks++; if (gfx1_ok !== 1'b0 || gfx2_ok !== 1'b0 || (c > 1 && sdram_req !== 1'b0)) begin errors++; $display("FAIL dl_cycle%0d got ok=%0b%0b req=%0b want 00 0", c, gfx1_ok, gfx2_ok, sdram_req); end
      tick();
      sdram_dst = 1'b0;
      sdram_din = '0;
    end
    downloading = 1'b0;
    #1;
    checks++; if (gfx1_ok !== 1'b0 || gfx2_ok !== 1'b0 || sdram_req !== 1'b0) begin errors++; $display("FAIL dl_release got ok=%0b%0b req=%0b want 00 0", gfx1_ok, gfx2_ok, sdram_req); end
    serve(16'h1111);
    checks++; if (!got || got_addr !== 22'h000100) begin errors++; $display("FAIL dl_rereq1 got %h want 000100", got_addr); end
    serve(16'h6666);
    checks++; if (!got || got_addr !== 22'h000050 || gfx2_ok !== 1'b1 || gfx2_data !== 16'h6666) begin errors++; $display("FAIL dl_rereq2 got addr=%h ok=%0b data=%h want 000050 1 6666", got_addr, gfx2_ok, gfx2_data); end
    gfx1_cs = 1'b0;
    gfx2_cs = 1'b0;
  endtask

  task automatic test_async_reset();
    tick();
    gfx1_addr = 18'h300;
    gfx1_cs   = 1'b1;
    tick();
    checks++; if (sdram_req !== 1'b1) begin errors++; $display("FAIL ar_req got %0b want 1", sdram_req); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (sdram_req !== 1'b0 || sdram_addr !== 22'd0) begin errors++; $display("FAIL ar_drop got req=%0b addr=%h want 0 0", sdram_req, sdram_addr); end
    gfx1_cs = 1'b0;
    tick();
    rst       = 1'b0;
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    sdram_dst = 1'b1;
    sdram_din = 16'hDEAD;
    tick();
    sdram_dst = 1'b0;
    sdram_din = '0;
    gfx1_cs   = 1'b1;
    #1;
    checks++; if (gfx1_ok !== 1'b0 || gfx1_data !== 16'd0) begin errors++; $display("FAIL ar_stray got ok=%0b data=%h want 0 0000", gfx1_ok, gfx1_data); end
    gfx1_cs = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_wrap();
    test_round_robin();
    test_addr_change();
    test_download();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
